// File: rtl/attosoc_mem_responder_if.sv
// ---------------------------------------------------------------------------
// attosoc_mem_responder_if
//   PicoRV32 native memory bus bundle.
//   master modport : CPU / initiator side (drives request, samples response)
//   slave modport  : responder side (samples request, drives response)
//   Signals:
//     mem_valid  request valid, held until mem_ready
//     mem_instr  instruction-fetch flag
//     mem_addr   byte address (word aligned)
//     mem_wdata  write data
//     mem_wstrb  byte write enables, 0 = read
//     mem_ready  one-cycle acknowledge
//     mem_rdata  read data, valid while mem_ready = 1
// ---------------------------------------------------------------------------
interface attosoc_mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/attosoc_mem_responder.sv
// ---------------------------------------------------------------------------
// attosoc_mem_responder
//   Target-side responder on the PicoRV32 native memory bus. Serves a word
//   RAM at 0x0000_0000 and an IO bank at IO_BASE (LED, TIMER, STATUS), with
//   WAIT_STATES programmable cycles of mem_ready back-pressure. Unmapped
//   addresses are acknowledged normally and set the sticky err flag.
//
//   Parameters:
//     MEM_WORDS   RAM depth in 32-bit words
//     WAIT_STATES extra cycles between capture and mem_ready (0..15)
//     IO_BASE     base address of the IO bank
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    memory bus, slave side (mem_valid/instr/addr/wdata/wstrb in,
//            mem_ready/rdata out)
//     led    LED register
//     err    sticky decode-error flag
//
//   Build option:
//     ATTOSOC_RESP_TIMER_EN  defined: free-running cycle timer at IO_BASE+0x4.
//                            undefined: no counter; IO_BASE+0x4 reads 0 and
//                            is still a mapped (non-error) address.
// ---------------------------------------------------------------------------
module attosoc_mem_responder #(
  parameter int unsigned MEM_WORDS   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] IO_BASE     = 32'h0200_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  attosoc_mem_responder_if.slave     bus,
  output logic [7:0]                 led,
  output logic                       err
);

  localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] IO_LED    = IO_BASE;
  localparam logic [31:0] IO_TIMER  = IO_BASE + 32'h4;
  localparam logic [31:0] IO_STATUS = IO_BASE + 32'h8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [7:0]  led_q;
  logic        err_q;

  logic [31:0] ram_q [MEM_WORDS];

  logic [31:0] dec_addr;
  logic [IDX_W-1:0] ram_idx;
  logic        hit_ram;
  logic        hit_led;
  logic        hit_timer;
  logic        hit_status;
  logic        hit_none;
  logic [31:0] timer_rd;
  logic [31:0] rdata_d;

  // Fetch flag only matters for external error logging; not consumed here.
  logic        unused_instr;
  assign unused_instr = bus.mem_instr;

  // With zero wait states the edge that captures the request is also the
  // edge that enters ACK, so the read path must decode the live bus address
  // in IDLE; in every other state it decodes the latched address.
  assign dec_addr = (state_q == S_IDLE) ? bus.mem_addr : addr_q;
  assign ram_idx  = dec_addr[IDX_W+1:2];

  assign hit_ram    = (dec_addr[31:24] == 8'h00) &&
                      ({2'b00, dec_addr[31:2]} < 32'(MEM_WORDS));
  assign hit_led    = (dec_addr == IO_LED);
  assign hit_timer  = (dec_addr == IO_TIMER);
  assign hit_status = (dec_addr == IO_STATUS);
  assign hit_none   = !(hit_ram || hit_led || hit_timer || hit_status);

`ifdef ATTOSOC_RESP_TIMER_EN
  logic [31:0] timer_q;

  // Counts every clock edge since reset release, independent of bus state.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    rdata_d = '0;
    if (hit_ram) begin
      rdata_d = ram_q[ram_idx];
    end else if (hit_led) begin
      rdata_d = {24'b0, led_q};
    end else if (hit_timer) begin
      rdata_d = timer_rd;
    end else if (hit_status) begin
      rdata_d = {31'b0, err_q};
    end
  end

  // Bus FSM with registered response and IO register side effects. All
  // write side effects happen on the edge leaving ACK, once per transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      led_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.mem_valid) begin
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            wstrb_q <= bus.mem_wstrb;
            if (WAIT_STATES == 0) begin
              state_q <= S_ACK;
              ready_q <= 1'b1;
              rdata_q <= rdata_d;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_STATES);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_q <= S_ACK;
            ready_q <= 1'b1;
            rdata_q <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          if (hit_led && wstrb_q[0]) begin
            led_q <= wdata_q[7:0];
          end
          if (hit_status && wstrb_q[0] && wdata_q[0]) begin
            err_q <= 1'b0;
          end
          if (hit_none) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM is not reset; a reset on the ACK edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_ACK) && hit_ram) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          ram_q[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign led           = led_q;
  assign err           = err_q;

endmodule

// File: tb/tb_attosoc_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_attosoc_mem_responder
//   Directed bench for attosoc_mem_responder. Two instances share clock and
//   reset: u_dut0 with WAIT_STATES=0 and u_dut3 with WAIT_STATES=3. TIMER
//   expectations follow ATTOSOC_RESP_TIMER_EN as compiled.
// ---------------------------------------------------------------------------
module tb_attosoc_mem_responder;

  localparam logic [31:0] IO_BASE = 32'h0200_0000;

  logic       clk;
  logic       reset;
  logic [7:0] led0, led3;
  logic       err0, err3;

  int n_checks = 0;
  int n_fail   = 0;

  attosoc_mem_responder_if b0 ();
  attosoc_mem_responder_if b3 ();

  attosoc_mem_responder #(
    .MEM_WORDS  (256),
    .WAIT_STATES(0),
    .IO_BASE    (IO_BASE)
  ) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (b0.slave),
    .led  (led0),
    .err  (err0)
  );

  attosoc_mem_responder #(
    .MEM_WORDS  (256),
    .WAIT_STATES(3),
    .IO_BASE    (IO_BASE)
  ) u_dut3 (
    .clk  (clk),
    .reset(reset),
    .bus  (b3.slave),
    .led  (led3),
    .err  (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d3, input logic v, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] s);
    if (d3) begin
      b3.mem_valid = v; b3.mem_instr = 1'b0; b3.mem_addr = a;
      b3.mem_wdata = w; b3.mem_wstrb = s;
    end else begin
      b0.mem_valid = v; b0.mem_instr = 1'b0; b0.mem_addr = a;
      b0.mem_wdata = w; b0.mem_wstrb = s;
    end
  endtask

  function automatic logic rdy(input bit d3);
    return d3 ? b3.mem_ready : b0.mem_ready;
  endfunction

  function automatic logic [31:0] rd(input bit d3);
    return d3 ? b3.mem_rdata : b0.mem_rdata;
  endfunction

  // One full transaction: request driven at a falling edge, the capture
  // edge is the next rising edge; latency counts rising edges up to the
  // first one after which mem_ready is seen high.
  task automatic xfer(input bit d3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input int exp_lat, input string tag,
                      output logic [31:0] rdata);
    int lat;
    bit seen;
    @(negedge clk);
    drive(d3, 1'b1, addr, wdata, wstrb);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rdy(d3)) seen = 1'b1;
    end
    check({tag, " ready seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    rdata = rd(d3);
    @(negedge clk);
    drive(d3, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    check({tag, " ready pulse"}, 32'(rdy(d3)), 32'd0);
    check({tag, " rdata idle"}, rd(d3), 32'd0);
  endtask

  logic [31:0] r, t1, t2;
  int gap;
  bit seen_ready;

  initial begin
    drive(1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready0", 32'(b0.mem_ready), 32'd0);
    check("rst rdata0", b0.mem_rdata, 32'd0);
    check("rst led0", 32'(led0), 32'd0);
    check("rst err0", 32'(err0), 32'd0);
    check("rst ready3", 32'(b3.mem_ready), 32'd0);
    reset = 1'b0;

    // Zero wait states: write then read back
    xfer(1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1, "ws0 wr10", r);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 1, "ws0 rd10", r);
    check("ws0 rd10 data", r, 32'hDEAD_BEEF);

    // Byte lanes
    xfer(1'b0, 32'h20, 32'h1122_3344, 4'hF, 1, "lane wr full", r);
    xfer(1'b0, 32'h20, 32'hAA00_0000, 4'h8, 1, "lane wr b3", r);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 1, "lane rd", r);
    check("lane rd data", r, 32'hAA22_3344);
    xfer(1'b0, 32'h20, 32'h0000_0055, 4'h1, 1, "lane wr b0", r);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 1, "lane rd2", r);
    check("lane rd2 data", r, 32'hAA22_3355);

    // Last RAM word is mapped
    xfer(1'b0, 32'h3FC, 32'h0BAD_F00D, 4'hF, 1, "ram top wr", r);
    xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 1, "ram top rd", r);
    check("ram top data", r, 32'h0BAD_F00D);
    check("ram top err", 32'(err0), 32'd0);

    // LED
    xfer(1'b0, IO_BASE, 32'h0000_005A, 4'h1, 1, "led wr", r);
    check("led value", 32'(led0), 32'h5A);
    xfer(1'b0, IO_BASE, 32'h0000_00FF, 4'h2, 1, "led wr no b0", r);
    check("led unchanged", 32'(led0), 32'h5A);
    xfer(1'b0, IO_BASE, 32'h0, 4'h0, 1, "led rd", r);
    check("led rd data", r, 32'h0000_005A);

    // TIMER: captures 10 edges apart
    xfer(1'b0, IO_BASE + 32'h4, 32'h0, 4'h0, 1, "timer rd a", t1);
    repeat (8) @(negedge clk);
    xfer(1'b0, IO_BASE + 32'h4, 32'h0, 4'h0, 1, "timer rd b", t2);
`ifdef ATTOSOC_RESP_TIMER_EN
    check("timer delta", t2 - t1, 32'd10);
`else
    check("timer a zero", t1, 32'd0);
    check("timer b zero", t2, 32'd0);
`endif
    xfer(1'b0, IO_BASE + 32'h4, 32'hFFFF_FFFF, 4'hF, 1, "timer wr", r);
    check("timer no err", 32'(err0), 32'd0);

    // Decode errors and write-1-to-clear
    xfer(1'b0, 32'h0100_0000, 32'h0, 4'h0, 1, "unmapped rd", r);
    check("unmapped data", r, 32'd0);
    check("unmapped err", 32'(err0), 32'd1);
    xfer(1'b0, IO_BASE + 32'h8, 32'h0, 4'h0, 1, "status rd", r);
    check("status data", r, 32'd1);
    xfer(1'b0, IO_BASE + 32'h8, 32'h1, 4'h1, 1, "status clr", r);
    check("status cleared", 32'(err0), 32'd0);
    xfer(1'b0, 32'h400, 32'h0, 4'h0, 1, "past ram rd", r);
    check("past ram err", 32'(err0), 32'd1);
    xfer(1'b0, IO_BASE + 32'h8, 32'h2, 4'h1, 1, "status wr0", r);
    check("status kept", 32'(err0), 32'd1);
    xfer(1'b0, IO_BASE + 32'h8, 32'h1, 4'h1, 1, "status clr2", r);
    check("status cleared2", 32'(err0), 32'd0);

    // Three wait states
    xfer(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 4, "ws3 wr0", r);
    xfer(1'b1, 32'h0, 32'h0, 4'h0, 4, "ws3 rd0", r);
    check("ws3 rd0 data", r, 32'hCAFE_F00D);

    // Back-to-back with mem_valid held: ACK, one IDLE, then 3+1 more edges
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    gap = 0;
    seen_ready = 1'b0;
    while (!seen_ready && gap < 40) begin
      @(posedge clk); #1;
      gap++;
      if (b3.mem_ready) seen_ready = 1'b1;
    end
    check("b2b first latency", 32'(gap), 32'd4);
    gap = 0;
    seen_ready = 1'b0;
    while (!seen_ready && gap < 40) begin
      @(posedge clk); #1;
      gap++;
      if (b3.mem_ready) seen_ready = 1'b1;
    end
    check("b2b ready spacing", 32'(gap), 32'd5);
    check("b2b data", b3.mem_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b1, 1'b0, '0, '0, '0);
    @(posedge clk); #1;

    // Reset during WAIT of a write
    xfer(1'b1, 32'h30, 32'h1234_5678, 4'hF, 4, "ws3 wr30", r);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0, '0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst mid ready", 32'(b3.mem_ready), 32'd0);
    check("rst led0", 32'(led0), 32'd0);
    check("rst led3", 32'(led3), 32'd0);
    // Capture at the 2nd edge after release; ACK entered 3 edges later,
    // sampling the timer after 4 counted edges.
    xfer(1'b1, IO_BASE + 32'h4, 32'h0, 4'h0, 4, "timer after rst", r);
`ifdef ATTOSOC_RESP_TIMER_EN
    check("timer restart", r, 32'd4);
`else
    check("timer restart", r, 32'd0);
`endif
    xfer(1'b1, 32'h30, 32'h0, 4'h0, 4, "ws3 rd30", r);
    check("dropped write", r, 32'h1234_5678);
    check("err3 clean", 32'(err3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/attosoc_mem_responder.md
Name: attosoc_mem_responder

Overview:
- Target-side responder on the PicoRV32 native memory bus. The CPU is the initiator; this block answers it.
- Services an on-chip word RAM plus a small IO register bank: LED output, cycle timer, and error status.
- Adds programmable wait states so firmware and benches can exercise `mem_ready` back-pressure.
- Answers unmapped addresses rather than hanging the bus.

Parameters:
- MEM_WORDS, 256: RAM depth in 32-bit words, mapped at 0x0000_0000.
- WAIT_STATES, 0: extra cycles inserted between capture and `mem_ready`; range 0..15.
- IO_BASE, 32'h0200_0000: base address of the IO register bank.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mem_valid  input  1  request valid; held high by the initiator until `mem_ready`
- mem_instr  input  1  instruction fetch flag; ignored except for decode-error logging
- mem_addr  input  32  byte address, word aligned
- mem_wdata  input  32  write data
- mem_wstrb  input  4  byte write enables; 0 means read
- mem_ready  output  1  one-cycle acknowledge
- mem_rdata  output  32  read data, valid while `mem_ready` = 1
- led  output  8  LED register
- err  output  1  sticky decode-error flag

Behaviour:
- Reset values: `mem_ready` = 0, `mem_rdata` = 0, `led` = 0, `err` = 0, timer = 0, FSM in IDLE. RAM contents are not reset.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - On `mem_valid` = 1, latch addr, wdata and wstrb.
  - Go to WAIT if WAIT_STATES > 0, else go to ACK.
- WAIT:
  - Counter counts down from WAIT_STATES.
  - When the counter reaches 1, go to ACK.
  - `mem_valid` is not re-sampled in this state.
- ACK:
  - `mem_ready` = 1 for exactly one cycle; `mem_rdata` is driven.
  - Writes commit on this clock edge only, so each transaction writes exactly once.
  - Next state is always IDLE; `mem_valid` is ignored in ACK.
- Latency:
  - Capture at edge N gives `mem_ready` high during the cycle after edge N + WAIT_STATES.
  - Minimum 2 cycles per transaction; next capture is possible in the IDLE cycle after ACK.
- Outside ACK, `mem_rdata` = 0.
- Read data is registered on the edge entering ACK, from the latched address.
- Decode is on the latched address:
  - RAM: `addr[31:24]` = 0x00 and `addr[31:2]` < MEM_WORDS.
    - Per-byte writes under wstrb; read returns the full word.
  - IO_BASE+0x0, LED:
    - Write with wstrb[0] sets `led` = wdata[7:0].
    - Read returns {24'b0, led}.
  - IO_BASE+0x4, TIMER: read-only 32-bit count of clock edges since reset deassertion. Wraps 0xFFFF_FFFF -> 0. Writes are ignored.
  - IO_BASE+0x8, STATUS:
    - Read returns {31'b0, err}.
    - Write with wstrb[0] and wdata[0] = 1 clears `err` (write-1-to-clear).
  - Any other address: still acknowledged with normal latency; read returns 0; write discarded; `err` set in ACK.
- Simultaneous events: a decode error and a STATUS clear cannot coincide (different addresses). The timer increments every cycle regardless of bus state.
- Reset mid-transaction: FSM returns to IDLE at that edge; `mem_ready` is low the next cycle; the pending write is dropped.
- `mem_valid` dropping before ACK is a protocol violation. The latched transaction still completes and is acknowledged.

Optional Feature:
- Macro: ATTOSOC_RESP_TIMER_EN.
- Defined: TIMER register implemented as described above.
- Undefined: no counter logic. IO_BASE+0x4 stays a mapped address: reads return 0, writes are ignored, and `err` is not set.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> `mem_ready` one cycle after capture each time; read data 0xDEADBEEF; no second write.
- Byte lanes: write 0x11223344 to 0x20 with wstrb=0xF, then write 0xAA000000 with wstrb=0x8, then read -> 0xAA223344.
- WAIT_STATES=3: read 0x0 -> `mem_ready` rises exactly 4 cycles after the capture edge, high for 1 cycle; back-to-back requests are separated by one IDLE cycle.
- IO:
  - Write 0x5A to IO_BASE -> `led` = 0x5A.
  - Read TIMER twice, 10 cycles apart -> difference = 10.
  - With the macro undefined, TIMER reads 0 and `err` stays 0.
- Unmapped read of 0x0100_0000 -> acknowledged, rdata = 0, `err` = 1. Write 0x1 to IO_BASE+0x8 -> `err` = 0.
- Assert reset during WAIT of a write to 0x30 (WAIT_STATES=3) -> no `mem_ready`, RAM[0x30] unchanged, `led` = 0, timer restarts at 0.
